// File: rtl/cast_switch_allocator_if.sv
// Selection/ready interface between the input buffers, the multicast
// switch allocator and the crossbar. The master side drives flit
// status, routing masks and downstream ready; the slave side (the
// allocator) returns crossbar selections, input ready and output busy.
interface cast_switch_allocator_if #(
   parameter int PN = 5
);
   logic [PN-1:0]          valid_i;
   logic [PN-1:0]          head_i;
   logic [PN-1:0]          tail_i;
   logic [PN-1:0][PN-1:0]  req_i;
   logic [PN-1:0]          out_ready_i;
   logic [PN-1:0][PN-1:0]  xbar_sel_o;
   logic [PN-1:0]          in_ready_o;
   logic [PN-1:0]          out_busy_o;

   modport master (
      output valid_i, head_i, tail_i, req_i, out_ready_i,
      input  xbar_sel_o, in_ready_o, out_busy_o
   );

   modport slave (
      input  valid_i, head_i, tail_i, req_i, out_ready_i,
      output xbar_sel_o, in_ready_o, out_busy_o
   );
endinterface

// File: rtl/cast_switch_allocator.sv
// Multicast switch allocator. Each input holds a registered output set
// (sel) from head to tail; allocation is a greedy all-or-nothing
// round-robin pass over idle inputs, and input ready is the lock-step
// AND of downstream ready over every output in the held set.
module cast_switch_allocator #(
   parameter int PN = 5
) (
   input logic                      clk,
   input logic                      rst,
   cast_switch_allocator_if.slave   bus
);

   localparam int PW = (PN > 1) ? $clog2(PN) : 1;

   logic [PN-1:0][PN-1:0] sel_q, sel_d;
   logic [PW-1:0]         ptr_q, ptr_d;
   logic [PN-1:0]         busy;
   logic [PN-1:0]         in_ready;
   logic [PN-1:0]         fire;
   logic [PN-1:0]         taken;
   logic                  found;
   logic [PW-1:0]         idx;
   int                    idx_int;
   int                    nxt;

   // Outputs owned by any locked input.
   always_comb begin
      busy = '0;
      for (int i = 0; i < PN; i++) begin
         busy = busy | sel_q[i];
      end
   end

   // Lock-step fork: an input is ready only when every selected output is ready.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < PN; i++) begin
         in_ready[i] = (sel_q[i] != '0) && ((sel_q[i] & ~bus.out_ready_i) == '0);
      end
   end

   assign fire = bus.valid_i & in_ready;

   // Round-robin greedy allocation on idle inputs, then tail release on locked ones.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise paths that skip an assignment would infer a latch.
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      taken   = busy;
      found   = 1'b0;
      idx_int = 0;
      idx     = '0;
      nxt     = 0;
      for (int k = 0; k < PN; k++) begin
         idx_int = int'(ptr_q) + k;
         if (idx_int >= PN) begin
            idx_int = idx_int - PN;
         end
         idx = PW'(idx_int);
         if ((sel_q[idx] == '0) && bus.valid_i[idx] && bus.head_i[idx] &&
             (bus.req_i[idx] != '0) && ((bus.req_i[idx] & taken) == '0)) begin
            sel_d[idx] = bus.req_i[idx];
            taken      = taken | bus.req_i[idx];
            if (!found) begin
               found = 1'b1;
               nxt   = idx_int + 1;
               if (nxt >= PN) begin
                  nxt = 0;
               end
               ptr_d = PW'(nxt);
            end
         end
      end
      // Release only touches locked inputs, allocation only idle ones, so
      // they never collide; freed outputs reach allocation next cycle via busy.
      for (int i = 0; i < PN; i++) begin
         if (fire[i] && bus.tail_i[i]) begin
            sel_d[i] = '0;
         end
      end
   end

   // Selection and pointer state; reset drops every lock immediately.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         sel_q <= '0;
         ptr_q <= '0;
      end else begin
         sel_q <= sel_d;
         ptr_q <= ptr_d;
      end
   end

   assign bus.xbar_sel_o = sel_q;
   assign bus.in_ready_o = in_ready;
   assign bus.out_busy_o = busy;

endmodule
